// File: rtl/register_file_mp.sv
// register_file_mp
// Parametrised multi-port integer register file with same-cycle write->read
// forwarding, write-collision detection and a sequential clear engine that
// zeroes one register per clock after reset or on request.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high; restarts the clear sweep
//   clear_req    in   start a clear sweep (only honoured while ready=1)
//   ready        out  1 = file usable, 0 = clear sweep in progress
//   read_enable  in   per read port enable
//   rs_addr      in   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_data      out  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   write_enable in   per write port enable
//   write_addr   in   write addresses, same packing as rs_addr
//   write_data   in   write data, same packing as rs_data
//   wr_conflict  out  previous edge saw >=2 enabled writes to one address
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  parameter int FORWARD    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_req,
  output logic                         ready,
  input  logic [NUM_RD-1:0]            read_enable,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data,
  input  logic [NUM_WR-1:0]            write_enable,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] write_data,
  output logic                         wr_conflict
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [ADDR_WIDTH-1:0]   clr_cnt_next;
  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
  logic [NUM_WR-1:0]       wr_commit;
  logic                    conflict_now;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_val;

  // An address is writable (and readable as storage) when it exists and is
  // not the hardwired zero register.
  function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < REG_COUNT) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready = (state == ST_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
        if (clr_cnt == LAST_IDX) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // Collisions are judged on raw enables and addresses, so writes that will
  // never commit (x0, out of range) still count.
  always_comb begin
    conflict_now = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (write_enable[j] && write_enable[k] &&
            (write_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == write_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          conflict_now = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_commit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_commit[j] = write_enable[j] && addr_writable(write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Writes in CLEAR are dropped, so no conflict can be flagged there either.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= (state == ST_READY) && conflict_now;
    end
  end

  // Register contents are deliberately left alone on the reset edge; the
  // sweep that follows zeroes them. Later write ports overwrite earlier ones
  // in the loop, giving highest-index priority on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        regs[clr_cnt] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_commit[j]) begin
            regs[write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Read ports: gated to zero unless enabled, READY and addressing real
  // storage; otherwise the highest matching committing write is bypassed.
  always_comb begin
    rs_data = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = rs_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val  = '0;
      if (read_enable[i] && (state == ST_READY) && addr_writable(rd_addr)) begin
        rd_val = regs[rd_addr];
        if (FORWARD != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_commit[j] && (write_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
              rd_val = write_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      rs_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
// Scoreboard bench for register_file_mp with default parameters (32 x 32-bit,
// 2 read ports, 2 write ports, x0 hardwired, forwarding on). Stimulus drives
// inputs 1 time unit after each rising edge and queues the expected outputs
// for that cycle; a monitor on the falling edge pops and compares them.
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        ready;
  logic [1:0]  read_enable;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  write_enable;
  logic [9:0]  write_addr;
  logic [63:0] write_data;
  logic        wr_conflict;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  localparam int SEL_RS0  = 0;
  localparam int SEL_RS1  = 1;
  localparam int SEL_RDY  = 2;
  localparam int SEL_CONF = 3;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  register_file_mp dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .ready        (ready),
    .read_enable  (read_enable),
    .rs_addr      (rs_addr),
    .rs_data      (rs_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .wr_conflict  (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic cr, input logic [1:0] re,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [1:0] we,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1);
    @(posedge clk);
    #1;
    rst          = r;
    clear_req    = cr;
    read_enable  = re;
    rs_addr      = {a1, a0};
    write_enable = we;
    write_addr   = {wa1, wa0};
    write_data   = {wd1, wd0};
  endtask

  task automatic readStep(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    applyStimulus(1'b0, 1'b0, re, a0, a1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic expectOut(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] got;
    case (e.sel)
      SEL_RS0:  got = rs_data[31:0];
      SEL_RS1:  got = rs_data[63:32];
      SEL_RDY:  got = {31'b0, ready};
      default:  got = {31'b0, wr_conflict};
    endcase
    checks++;
    if (got !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.val);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst          = 1'b1;
    clear_req    = 1'b0;
    read_enable  = 2'b00;
    rs_addr      = '0;
    write_enable = 2'b00;
    write_addr   = '0;
    write_data   = '0;

    // Release reset after one edge; outputs are in their reset state.
    readStep(2'b11, 5'd1, 5'd2);
    expectOut("reset ready", SEL_RDY, 32'h0);
    expectOut("reset conflict", SEL_CONF, 32'h0);
    expectOut("reset rs0", SEL_RS0, 32'h0);
    expectOut("reset rs1", SEL_RS1, 32'h0);

    // Reset sweep: ready rises only after the 32nd edge. A colliding write
    // during the sweep is dropped and flags nothing.
    for (int k = 1; k <= 32; k++) begin
      if (k == 10)
        applyStimulus(1'b0, 1'b0, 2'b11, 5'd3, 5'd7, 2'b11, 5'd3, 32'h99, 5'd3, 32'h9A);
      else
        readStep(2'b11, 5'(k), 5'(31 - k));
      expectOut($sformatf("sweep%0d ready", k), SEL_RDY, (k == 32) ? 32'h1 : 32'h0);
      expectOut($sformatf("sweep%0d conflict", k), SEL_CONF, 32'h0);
      expectOut($sformatf("sweep%0d rs0", k), SEL_RS0, 32'h0);
      expectOut($sformatf("sweep%0d rs1", k), SEL_RS1, 32'h0);
    end

    // x0 write is never stored nor forwarded, and a lone write is no conflict.
    applyStimulus(1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0);
    expectOut("x0 fwd rs0", SEL_RS0, 32'h0);
    expectOut("x0 fwd rs1", SEL_RS1, 32'h0);
    readStep(2'b11, 5'd0, 5'd0);
    expectOut("x0 rs0", SEL_RS0, 32'h0);
    expectOut("x0 rs1", SEL_RS1, 32'h0);
    expectOut("x0 conflict", SEL_CONF, 32'h0);

    // Dropped write from the sweep left x3 at zero.
    readStep(2'b11, 5'd3, 5'd7);
    expectOut("clear-drop x3", SEL_RS0, 32'h0);
    expectOut("clear-drop x7", SEL_RS1, 32'h0);

    // Dual write to different addresses: forwarded, then stored.
    applyStimulus(1'b0, 1'b0, 2'b11, 5'd1, 5'd2, 2'b11, 5'd1, 32'h12345678, 5'd2, 32'hAABBCCDD);
    expectOut("dual fwd rs0", SEL_RS0, 32'h12345678);
    expectOut("dual fwd rs1", SEL_RS1, 32'hAABBCCDD);
    readStep(2'b11, 5'd1, 5'd2);
    expectOut("dual rs0", SEL_RS0, 32'h12345678);
    expectOut("dual rs1", SEL_RS1, 32'hAABBCCDD);
    expectOut("dual conflict", SEL_CONF, 32'h0);

    // Collision on x3: highest port wins, conflict for exactly one cycle.
    applyStimulus(1'b0, 1'b0, 2'b11, 5'd3, 5'd3, 2'b11, 5'd3, 32'h11111111, 5'd3, 32'h22222222);
    expectOut("coll fwd rs0", SEL_RS0, 32'h22222222);
    expectOut("coll fwd rs1", SEL_RS1, 32'h22222222);
    expectOut("coll pre conflict", SEL_CONF, 32'h0);
    readStep(2'b11, 5'd3, 5'd1);
    expectOut("coll x3", SEL_RS0, 32'h22222222);
    expectOut("coll x1 kept", SEL_RS1, 32'h12345678);
    expectOut("coll conflict", SEL_CONF, 32'h1);
    readStep(2'b01, 5'd3, 5'd3);
    expectOut("coll after conflict", SEL_CONF, 32'h0);
    expectOut("coll after rs1 off", SEL_RS1, 32'h0);

    // Two writes to x0 still count as a collision.
    applyStimulus(1'b0, 1'b0, 2'b11, 5'd0, 5'd3, 2'b11, 5'd0, 32'hA, 5'd0, 32'hB);
    expectOut("x0coll rs0", SEL_RS0, 32'h0);
    readStep(2'b11, 5'd0, 5'd3);
    expectOut("x0coll conflict", SEL_CONF, 32'h1);
    expectOut("x0coll rs0 after", SEL_RS0, 32'h0);
    expectOut("x0coll x3 kept", SEL_RS1, 32'h22222222);

    // read_enable gating, including over a forwarded write.
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd5, 5'd5, 2'b01, 5'd5, 32'h5555AAAA, 5'd0, 32'h0);
    expectOut("re0 fwd rs0", SEL_RS0, 32'h0);
    expectOut("re0 fwd rs1", SEL_RS1, 32'h0);
    readStep(2'b00, 5'd5, 5'd5);
    expectOut("re0 rs0", SEL_RS0, 32'h0);
    expectOut("re0 rs1", SEL_RS1, 32'h0);
    readStep(2'b01, 5'd5, 5'd5);
    expectOut("re01 rs0", SEL_RS0, 32'h5555AAAA);
    expectOut("re01 rs1", SEL_RS1, 32'h0);
    readStep(2'b11, 5'd5, 5'd5);
    expectOut("re11 rs0", SEL_RS0, 32'h5555AAAA);
    expectOut("re11 rs1", SEL_RS1, 32'h5555AAAA);

    // Clear request mid-operation; the request edge's write still commits.
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd4, 5'd0, 2'b01, 5'd4, 32'hFFFF0000, 5'd0, 32'h0);
    expectOut("x4 fwd", SEL_RS0, 32'hFFFF0000);
    applyStimulus(1'b0, 1'b1, 2'b11, 5'd4, 5'd8, 2'b10, 5'd0, 32'h0, 5'd8, 32'h88);
    expectOut("clrreq x4", SEL_RS0, 32'hFFFF0000);
    expectOut("clrreq x8 fwd", SEL_RS1, 32'h88);
    expectOut("clrreq ready", SEL_RDY, 32'h1);
    readStep(2'b11, 5'd4, 5'd8);
    expectOut("clr0 ready", SEL_RDY, 32'h0);
    expectOut("clr0 rs0 gated", SEL_RS0, 32'h0);
    expectOut("clr0 rs1 gated", SEL_RS1, 32'h0);

    // Reset on sweep edge 10 restarts the whole sweep.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus((k == 9) ? 1'b1 : 1'b0, 1'b0, 2'b11, 5'd4, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      expectOut($sformatf("clr%0d ready", k), SEL_RDY, 32'h0);
      expectOut($sformatf("clr%0d rs0", k), SEL_RS0, 32'h0);
    end
    readStep(2'b11, 5'd4, 5'd5);
    expectOut("clr rst ready", SEL_RDY, 32'h0);
    expectOut("clr rst conflict", SEL_CONF, 32'h0);
    for (int m = 1; m <= 32; m++) begin
      applyStimulus(1'b0, (m == 5) ? 1'b1 : 1'b0, 2'b11, 5'd4, 5'd8, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      expectOut($sformatf("resweep%0d ready", m), SEL_RDY, (m == 32) ? 32'h1 : 32'h0);
    end

    // After the sweep every register reads zero; the file works again.
    readStep(2'b11, 5'd4, 5'd8);
    expectOut("post x4", SEL_RS0, 32'h0);
    expectOut("post x8", SEL_RS1, 32'h0);
    readStep(2'b11, 5'd1, 5'd5);
    expectOut("post x1", SEL_RS0, 32'h0);
    expectOut("post x5", SEL_RS1, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'd31, 32'hCAFEF00D);
    readStep(2'b10, 5'd0, 5'd31);
    expectOut("post x31", SEL_RS1, 32'hCAFEF00D);
    expectOut("post ready", SEL_RDY, 32'h1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
